pn_token_sink: RTL

PN_TOKEN_SINK -- requirements
Module: pn_token_sink

---
 rtl/pn_token_sink.sv | 71 +++++++
 1 files changed

// File: rtl/pn_token_sink.sv
// Token sink: takes one upstream token per TAKE cycle into a bounded holding
// count, releases tokens downstream on a valid/ready handshake.
module pn_token_sink #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             tok_in,
   output logic             tok_take,
   output logic             dn_valid,
   input  logic             dn_ready,
   output logic [7:0]       occupancy,
   output logic             full,
   output logic [CNT_W-1:0] tok_count
);

   typedef enum logic {IDLE, TAKE} state_t;

   localparam logic [7:0]       DEPTH_V = 8'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_reg, state_next;
   logic [7:0]       occ_reg, occ_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             push, pop;

   assign pop  = dn_valid & dn_ready;
   assign push = (state_reg == TAKE);

   // A take may start into a full store only when a slot frees at the same edge.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (tok_in && en && ((occ_reg < DEPTH_V) || pop)) state_next = TAKE;
         TAKE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      occ_next   = occ_reg;
      count_next = count_reg;
      case ({push, pop})
         2'b10:   occ_next = occ_reg + 8'd1;
         2'b01:   occ_next = occ_reg - 8'd1;
         default: occ_next = occ_reg;
      endcase
      if (push) count_next = count_reg + CNT_ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         occ_reg   <= 8'd0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         occ_reg   <= occ_next;
         count_reg <= count_next;
      end
   end

   assign tok_take  = (state_reg == TAKE);
   assign occupancy = occ_reg;
   assign dn_valid  = (occ_reg != 8'd0);
   assign full      = (occ_reg == DEPTH_V);
   assign tok_count = count_reg;

endmodule
